// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - frame-buffer RAM arbiter: fixed-latency VGA reads, round-robin GPU read/write ports.
// Optional write-stall counter enabled by defining FB_ARB_STATS_EN.
module fb_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       wr_stall_cnt
`endif
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_GPU} tag_e;

  logic              gnt_vga, gnt_wr, gnt_rd;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  tag_e              tag1_q, tag1_d, tag2_q;

  // VGA always wins; on GPU contention rr_last=0 favours the read port.
  always_comb begin
    gnt_vga = vga_req;
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;
    if (!vga_req) begin
      if (wr_valid && rd_valid) begin
        if (rr_last_q) gnt_wr = 1'b1;
        else           gnt_rd = 1'b1;
      end else if (wr_valid) begin
        gnt_wr = 1'b1;
      end else if (rd_valid) begin
        gnt_rd = 1'b1;
      end
    end
  end

  assign wr_ready = gnt_wr && !reset;
  assign rd_ready = gnt_rd && !reset;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    tag1_d      = TAG_NONE;
    rr_last_d   = rr_last_q;
    if (gnt_vga) begin
      mem_addr_d = vga_addr;
      tag1_d     = TAG_VGA;
    end else if (gnt_wr) begin
      mem_addr_d  = wr_addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = wr_data;
      rr_last_d   = 1'b0;
    end else if (gnt_rd) begin
      mem_addr_d = rd_addr;
      tag1_d     = TAG_GPU;
      rr_last_d  = 1'b1;
    end
  end

  // tag2_q lines up with the cycle in which mem_rdata carries the tagged read.
  always_comb begin
    vga_data_d = vga_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (tag2_q == TAG_VGA) begin
      vga_data_d = mem_rdata;
    end else if (tag2_q == TAG_GPU) begin
      rd_data_d  = mem_rdata;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vga_data_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
    end else begin
      rr_last_q   <= rr_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vga_data_q  <= vga_data_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign vga_data      = vga_data_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
    end else if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule
